// File: rtl/seq_acc_core.sv
// Sequencer for the QR compute-in-SRAM macro: SRAM row access plus
// bit-plane MAC with thermometer-ADC shift-accumulation and saturation.
module seq_acc_core #(
   parameter int inputBits      = 5,
   parameter int inputElements  = 128,
   parameter int outputBits     = 8,
   parameter int outputElements = 32,
   parameter int adcBits        = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   cfg_binary,
   input  logic [inputElements*inputBits-1:0]     mac_data_i,
   input  logic                                   mac_valid_i,
   output logic                                   ready_o,
   output logic                                   valid_o,
   output logic [outputElements*outputBits-1:0]   mac_data_o,
   input  logic                                   rq_valid_i,
   output logic                                   rq_ready_o,
   input  logic                                   rq_wr_i,
   input  logic [$clog2(inputElements)-1:0]       addr_i,
   input  logic [outputElements-1:0]              wr_data_i,
   output logic [outputElements-1:0]              rd_data_o,
   output logic                                   rd_valid_o,
   output logic [inputElements-1:0]              WL,
   output logic                                   PCH,
   output logic                                   WRITE,
   output logic                                   SAEN,
   output logic [outputElements-1:0]              WR_DATA,
   output logic [outputElements-1:0]              CSEL,
   input  logic [outputElements-1:0]              SA_OUT,
   output logic [inputElements-1:0]              VDR_SEL,
   output logic [inputElements-1:0]              VDR_SELB,
   output logic [inputElements-1:0]              VSS_SEL,
   output logic [inputElements-1:0]              VSS_SELB,
   output logic [inputElements-1:0]              VRST_SEL,
   output logic [inputElements-1:0]              VRST_SELB,
   input  logic [(2**adcBits-1)*outputElements-1:0] ADC_OUT,
   output logic                                   NF,
   output logic                                   NFB,
   output logic                                   M2A,
   output logic                                   M2AB,
   output logic                                   R2A,
   output logic                                   R2AB,
   output logic                                   CLK_A
);

   localparam int T    = inputBits - 1;
   localparam int C    = 2**adcBits - 1;
   localparam int AW   = $clog2(inputElements);
   localparam int PW   = $clog2(inputBits);
   localparam int ACCW = adcBits + inputBits + 1;
   localparam logic signed [ACCW-1:0] SMAX = ACCW'(2**(outputBits-1) - 1);
   localparam logic signed [ACCW-1:0] SMIN = -ACCW'(2**(outputBits-1));
   localparam logic [ACCW-1:0] OFS = ACCW'(2**(adcBits-1));

   typedef enum logic [3:0] {
      IDLE, WR, RD_PCH, RD_SENSE, RD_OUT,
      MAC_RST, MAC_EVAL, MAC_SAMPLE, MAC_OUT
   } state_t;

   state_t                            state;
   logic [AW-1:0]                     addr_q;
   logic [inputElements*inputBits-1:0] mag_q, mag_n;
   logic [inputElements-1:0]          sgn_q, sgn_n;
   logic                              mode_q;
   logic [PW-1:0]                     plane;
   logic signed [ACCW-1:0]            acc     [outputElements];
   logic signed [ACCW-1:0]            acc_nxt [outputElements];
   logic [inputElements-1:0]          ev_vdr, ev_vss, ev_vrst;

   function automatic logic [outputBits-1:0] sat(input logic signed [ACCW-1:0] a);
      if (a > SMAX)      return {1'b0, {(outputBits-1){1'b1}}};
      else if (a < SMIN) return {1'b1, {(outputBits-1){1'b0}}};
      else               return a[outputBits-1:0];
   endfunction

   assign rq_ready_o = (state == IDLE);
   assign ready_o    = (state == IDLE) & ~rq_valid_i;
   assign CSEL       = '1;
   assign CLK_A      = clk;
   assign NF         = ~cfg_binary;
   assign NFB        = ~NF;
   assign M2AB       = ~M2A;
   assign R2AB       = ~R2A;
   assign VDR_SELB   = ~VDR_SEL;
   assign VSS_SELB   = ~VSS_SEL;
   assign VRST_SELB  = ~VRST_SEL;

   // Ternary: two's complement -> sign + magnitude clipped to T bits
   always_comb begin
      logic [inputBits-1:0] x;
      logic [inputBits-1:0] ab;
      x     = '0;
      ab    = '0;
      mag_n = '0;
      sgn_n = '0;
      for (int r = 0; r < inputElements; r++) begin
         x = mac_data_i[r*inputBits +: inputBits];
         if (cfg_binary) begin
            mag_n[r*inputBits +: inputBits] = x;
         end else begin
            sgn_n[r] = x[inputBits-1];
            ab = x[inputBits-1] ? -x : x;
            if (ab > inputBits'(2**T - 1)) ab = inputBits'(2**T - 1);
            mag_n[r*inputBits +: inputBits] = ab;
         end
      end
   end

   always_comb begin
      logic b;
      b       = 1'b0;
      ev_vdr  = '0;
      ev_vss  = '0;
      ev_vrst = '0;
      for (int r = 0; r < inputElements; r++) begin
         b = mag_q[r*inputBits + int'(plane)];
         if (mode_q) begin
            ev_vdr[r] = b;
            ev_vss[r] = ~b;
         end else begin
            ev_vdr[r]  = b & ~sgn_q[r];
            ev_vss[r]  = b & sgn_q[r];
            ev_vrst[r] = ~b;
         end
      end
   end

   always_comb begin
      logic [adcBits-1:0] code;
      code = '0;
      for (int c = 0; c < outputElements; c++) begin
         code = '0;
         for (int j = 0; j < C; j++)
            code = code + adcBits'(ADC_OUT[c*C + j]);
         acc_nxt[c] = (acc[c] <<< 1) + $signed(ACCW'(code) - OFS);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         addr_q     <= '0;
         mag_q      <= '0;
         sgn_q      <= '0;
         mode_q     <= 1'b0;
         plane      <= '0;
         WL         <= '0;
         PCH        <= 1'b0;
         WRITE      <= 1'b0;
         SAEN       <= 1'b0;
         WR_DATA    <= '0;
         VDR_SEL    <= '0;
         VSS_SEL    <= '0;
         VRST_SEL   <= '0;
         M2A        <= 1'b0;
         R2A        <= 1'b0;
         valid_o    <= 1'b0;
         rd_valid_o <= 1'b0;
         rd_data_o  <= '0;
         mac_data_o <= '0;
         for (int c = 0; c < outputElements; c++) acc[c] <= '0;
      end else begin
         valid_o    <= 1'b0;
         rd_valid_o <= 1'b0;
         unique case (state)
            IDLE: begin
               if (rq_valid_i) begin
                  addr_q <= addr_i;
                  if (rq_wr_i) begin
                     state   <= WR;
                     WL      <= inputElements'(1) << addr_i;
                     WRITE   <= 1'b1;
                     WR_DATA <= wr_data_i;
                  end else begin
                     state <= RD_PCH;
                     PCH   <= 1'b1;
                  end
               end else if (mac_valid_i) begin
                  mag_q    <= mag_n;
                  sgn_q    <= sgn_n;
                  mode_q   <= cfg_binary;
                  plane    <= cfg_binary ? PW'(inputBits - 1) : PW'(T - 1);
                  for (int c = 0; c < outputElements; c++) acc[c] <= '0;
                  VRST_SEL <= '1;
                  R2A      <= 1'b1;
                  state    <= MAC_RST;
               end
            end
            WR: begin
               WL    <= '0;
               WRITE <= 1'b0;
               state <= IDLE;
            end
            RD_PCH: begin
               PCH   <= 1'b0;
               WL    <= inputElements'(1) << addr_q;
               SAEN  <= 1'b1;
               state <= RD_SENSE;
            end
            RD_SENSE: begin
               WL         <= '0;
               SAEN       <= 1'b0;
               rd_data_o  <= SA_OUT;
               rd_valid_o <= 1'b1;
               state      <= RD_OUT;
            end
            RD_OUT: state <= IDLE;
            MAC_RST: begin
               R2A      <= 1'b0;
               M2A      <= 1'b1;
               VDR_SEL  <= ev_vdr;
               VSS_SEL  <= ev_vss;
               VRST_SEL <= ev_vrst;
               state    <= MAC_EVAL;
            end
            MAC_EVAL: begin
               M2A   <= 1'b0;
               state <= MAC_SAMPLE;
            end
            MAC_SAMPLE: begin
               for (int c = 0; c < outputElements; c++) acc[c] <= acc_nxt[c];
               VDR_SEL <= '0;
               VSS_SEL <= '0;
               if (plane == '0) begin
                  VRST_SEL <= '0;
                  state    <= MAC_OUT;
               end else begin
                  plane    <= plane - 1'b1;
                  VRST_SEL <= '1;
                  R2A      <= 1'b1;
                  state    <= MAC_RST;
               end
            end
            MAC_OUT: begin
               for (int c = 0; c < outputElements; c++)
                  mac_data_o[c*outputBits +: outputBits] <= sat(acc[c]);
               valid_o <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_acc_core.sv
// Directed bench for seq_acc_core: SRAM write/read, ternary and binary
// MAC results, saturation, arbitration and mid-operation reset.
module tb_seq_acc_core;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_binary;
   logic [639:0]  mac_data_i;
   logic          mac_valid_i;
   logic          ready_o, valid_o;
   logic [255:0]  mac_data_o;
   logic          rq_valid_i, rq_ready_o, rq_wr_i;
   logic [6:0]    addr_i;
   logic [31:0]   wr_data_i, rd_data_o;
   logic          rd_valid_o;
   logic [127:0]  WL;
   logic          PCH, WRITE, SAEN;
   logic [31:0]   WR_DATA, CSEL, SA_OUT;
   logic [127:0]  VDR_SEL, VDR_SELB, VSS_SEL, VSS_SELB, VRST_SEL, VRST_SELB;
   logic [479:0]  ADC_OUT;
   logic          NF, NFB, M2A, M2AB, R2A, R2AB, CLK_A;

   int vectors = 0;
   int miscompares = 0;
   int lat;
   int seen;
   logic [255:0] exp_d;

   localparam logic [127:0] ONES128 = {128{1'b1}};

   seq_acc_core dut (
      .clk(clk), .rst(rst), .cfg_binary(cfg_binary),
      .mac_data_i(mac_data_i), .mac_valid_i(mac_valid_i),
      .ready_o(ready_o), .valid_o(valid_o), .mac_data_o(mac_data_o),
      .rq_valid_i(rq_valid_i), .rq_ready_o(rq_ready_o), .rq_wr_i(rq_wr_i),
      .addr_i(addr_i), .wr_data_i(wr_data_i), .rd_data_o(rd_data_o),
      .rd_valid_o(rd_valid_o), .WL(WL), .PCH(PCH), .WRITE(WRITE),
      .SAEN(SAEN), .WR_DATA(WR_DATA), .CSEL(CSEL), .SA_OUT(SA_OUT),
      .VDR_SEL(VDR_SEL), .VDR_SELB(VDR_SELB), .VSS_SEL(VSS_SEL),
      .VSS_SELB(VSS_SELB), .VRST_SEL(VRST_SEL), .VRST_SELB(VRST_SELB),
      .ADC_OUT(ADC_OUT), .NF(NF), .NFB(NFB), .M2A(M2A), .M2AB(M2AB),
      .R2A(R2A), .R2AB(R2AB), .CLK_A(CLK_A)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [639:0] fill_x(input logic [4:0] v);
      logic [639:0] f;
      for (int r = 0; r < 128; r++) f[r*5 +: 5] = v;
      return f;
   endfunction

   function automatic logic [479:0] adc_const(input int code);
      logic [479:0] a;
      for (int c = 0; c < 32; c++)
         for (int j = 0; j < 15; j++) a[c*15 + j] = (j < code);
      return a;
   endfunction

   function automatic logic [479:0] adc_ramp();
      logic [479:0] a;
      for (int c = 0; c < 32; c++)
         for (int j = 0; j < 15; j++) a[c*15 + j] = (j < (c % 16));
      return a;
   endfunction

   function automatic logic [255:0] rep8(input logic [7:0] b);
      return {32{b}};
   endfunction

   task automatic mac_start(input logic bin, input logic [639:0] x);
      cfg_binary  = bin;
      mac_data_i  = x;
      mac_valid_i = 1'b1;
      chk("mac_ready", ready_o, 1);
      step();
      mac_valid_i = 1'b0;
   endtask

   task automatic wait_valid(input int start, output int l);
      int cyc;
      cyc = start;
      while (valid_o !== 1'b1 && cyc < 40) begin
         step();
         cyc++;
      end
      l = cyc;
   endtask

   initial begin
      rst = 1'b1; cfg_binary = 1'b0; mac_data_i = '0; mac_valid_i = 1'b0;
      rq_valid_i = 1'b0; rq_wr_i = 1'b0; addr_i = '0; wr_data_i = '0;
      SA_OUT = '0; ADC_OUT = '0;
      step(); step();
      rst = 1'b0;
      chk("rst_wl", WL, 0);
      chk("rst_pch", PCH, 0);
      chk("rst_vrstb", VRST_SELB, ONES128);
      chk("rst_csel", CSEL, 32'hFFFF_FFFF);
      chk("rst_rqready", rq_ready_o, 1);
      chk("rst_macdata", mac_data_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("nf_ternary", {NF, NFB}, 2'b10);

      // SRAM write
      rq_valid_i = 1'b1; rq_wr_i = 1'b1; addr_i = 7'd5;
      wr_data_i = 32'hA5A5_A5A5;
      step();
      rq_valid_i = 1'b0;
      chk("wr_wl", WL, 128'd1 << 5);
      chk("wr_write", WRITE, 1);
      chk("wr_data", WR_DATA, 32'hA5A5_A5A5);
      chk("wr_busy", rq_ready_o, 0);
      step();
      chk("wr_done", {WL == 0, WRITE, rq_ready_o}, 3'b101);

      // SRAM read
      SA_OUT = 32'hA5A5_A5A5;
      rq_valid_i = 1'b1; rq_wr_i = 1'b0; addr_i = 7'd5;
      step();
      rq_valid_i = 1'b0;
      chk("rd_pch", {PCH, WL == 0}, 2'b11);
      step();
      chk("rd_sense", {PCH, SAEN}, 2'b01);
      chk("rd_wl", WL, 128'd1 << 5);
      step();
      chk("rd_valid", rd_valid_o, 1);
      chk("rd_data", rd_data_o, 32'hA5A5_A5A5);
      step();
      chk("rd_hold", {rd_valid_o, rq_ready_o, rd_data_o}, {2'b01, 32'hA5A5_A5A5});

      // Ternary MAC, x=+5, ADC code 15 -> 7*15
      ADC_OUT = adc_const(15);
      mac_start(1'b0, fill_x(5'd5));
      chk("mrst_vrst", VRST_SEL, ONES128);
      chk("mrst_r2a", {R2A, R2AB, ready_o}, 3'b100);
      step();
      chk("eval3_m2a", {M2A, M2AB}, 2'b10);
      chk("eval3_vrst", VRST_SEL, ONES128);
      step(); step(); step();
      chk("eval2_vdr", VDR_SEL, ONES128);
      chk("eval2_vdrb", VDR_SELB, 0);
      chk("eval2_vrst", VRST_SEL, 0);
      wait_valid(4, lat);
      chk("t5_lat", lat, 13);
      chk("t5_data", mac_data_o, rep8(8'd105));
      step();
      chk("t5_pulse", {valid_o, mac_data_o == rep8(8'd105)}, 2'b01);

      // Ternary x=-16 clipped to 15 on VSS, ADC code 0 -> -120
      ADC_OUT = adc_const(0);
      mac_start(1'b0, fill_x(5'b10000));
      step();
      chk("neg_vss", VSS_SEL, ONES128);
      chk("neg_vdr", {VDR_SEL, VRST_SEL}, 0);
      wait_valid(1, lat);
      chk("neg_lat", lat, 13);
      chk("neg_data", mac_data_o, rep8(8'h88));

      // Binary x=31, ADC code 15 -> 217 saturates to 127
      cfg_binary = 1'b1;
      #1 chk("nf_binary", {NF, NFB}, 2'b01);
      ADC_OUT = adc_const(15);
      mac_start(1'b1, fill_x(5'd31));
      step();
      chk("bin_vdr", {VDR_SEL, VSS_SEL}, {ONES128, 128'd0});
      wait_valid(1, lat);
      chk("bin_lat", lat, 16);
      chk("bin_satp", mac_data_o, rep8(8'h7F));

      // Binary x=0, ADC code 0 -> -248 saturates to -128
      ADC_OUT = adc_const(0);
      mac_start(1'b1, fill_x(5'd0));
      step();
      chk("bin0_vss", {VDR_SEL, VSS_SEL, VRST_SEL}, {128'd0, ONES128, 128'd0});
      wait_valid(1, lat);
      chk("bin_satn", mac_data_o, rep8(8'h80));

      // Per-column ramp: column c code c%16 -> 15*(c%16-8)
      ADC_OUT = adc_ramp();
      for (int c = 0; c < 32; c++) exp_d[c*8 +: 8] = 8'(15 * ((c % 16) - 8));
      mac_start(1'b0, fill_x(5'd3));
      wait_valid(0, lat);
      chk("ramp_data", mac_data_o, exp_d);

      // Plane order: only first plane has v=+1 -> weight 8
      ADC_OUT = adc_const(9);
      mac_start(1'b0, fill_x(5'd1));
      step(); step(); step();
      ADC_OUT = adc_const(8);
      wait_valid(3, lat);
      chk("order_lat", lat, 13);
      chk("order_data", mac_data_o, rep8(8'h08));

      // Simultaneous SRAM and MAC requests: SRAM first
      SA_OUT = 32'h3C3C_0FF0;
      cfg_binary = 1'b0; mac_data_i = fill_x(5'd2);
      rq_valid_i = 1'b1; rq_wr_i = 1'b0; addr_i = 7'd7; mac_valid_i = 1'b1;
      #1 chk("arb_ready", {ready_o, rq_ready_o}, 2'b01);
      step();
      rq_valid_i = 1'b0; mac_valid_i = 1'b0;
      chk("arb_pch", {PCH, R2A}, 2'b10);
      step(); step();
      chk("arb_rd", {rd_valid_o, rd_data_o}, {1'b1, 32'h3C3C_0FF0});
      step();

      // Reset during MAC_EVAL aborts cleanly
      ADC_OUT = adc_const(15);
      mac_start(1'b0, fill_x(5'd5));
      step();
      chk("abort_eval", M2A, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_sel", {VDR_SEL, VSS_SEL, VRST_SEL}, 0);
      chk("abort_selb", VRST_SELB & VDR_SELB & VSS_SELB, ONES128);
      chk("abort_ctl", {M2A, M2AB, R2A, R2AB, rq_ready_o}, 5'b01011);
      chk("abort_data", mac_data_o, 0);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (valid_o === 1'b1) seen = 1;
         step();
      end
      chk("abort_novalid", seen, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
